// File: rtl/reg_writeback_arbiter_if.sv
// Writeback request/response bundle between the EX/MEM producers, the register
// file write port and the hazard unit's pending-write lookup.
interface reg_writeback_arbiter_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                     mem_valid;
  logic                     mem_ready;
  logic [ADDR_W-1:0]        mem_rd;
  logic [DATA_W-1:0]        mem_data;
  logic                     alu_valid;
  logic                     alu_ready;
  logic [ADDR_W-1:0]        alu_rd;
  logic [DATA_W-1:0]        alu_data;
  logic                     RegWrite;
  logic [ADDR_W-1:0]        Rd;
  logic [DATA_W-1:0]        Write_data;
  logic [ADDR_W-1:0]        q_rs1;
  logic [ADDR_W-1:0]        q_rs2;
  logic                     pend1;
  logic                     pend2;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, q_rs1, q_rs2,
    output mem_ready, alu_ready, RegWrite, Rd, Write_data, pend1, pend2, count
  );

  modport master (
    output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, q_rs1, q_rs2,
    input  mem_ready, alu_ready, RegWrite, Rd, Write_data, pend1, pend2, count
  );
endinterface

// File: rtl/reg_writeback_arbiter.sv
// Two-producer writeback arbiter: in-order FIFO feeding a registered register-file
// write port, with a combinational pending-write lookup for hazard detection.
module reg_writeback_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  reg_writeback_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_2nd;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              mem_ready, alu_ready;
  logic              mem_enq, alu_enq, deq;
  logic [DEPTH-1:0]  entry_valid, hit1, hit2;

  // Ready depends only on registered occupancy, so a same-cycle pop never helps.
  assign mem_ready  = count_q <  CNT_W'(DEPTH);
  assign alu_ready  = count_q <= CNT_W'(DEPTH - 2);

  // Requests to x0 complete the handshake but are never queued.
  assign mem_enq    = bus.mem_valid && mem_ready && (bus.mem_rd != '0);
  assign alu_enq    = bus.alu_valid && alu_ready && (bus.alu_rd != '0);
  assign deq        = (count_q != '0);
  assign wr_ptr_2nd = wr_ptr_q + PTR_W'(mem_enq);

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(mem_enq) + PTR_W'(alu_enq);
    rd_ptr_d   = rd_ptr_q + PTR_W'(deq);
    count_d    = count_q + CNT_W'(mem_enq) + CNT_W'(alu_enq) - CNT_W'(deq);
    regwrite_d = deq;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    if (deq) begin
      rd_d    = rd_mem[rd_ptr_q];
      wdata_d = data_mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
    end
  end

  // mem is the older instruction, so it takes the first free slot.
  always_ff @(posedge clk) begin
    if (mem_enq) begin
      rd_mem[wr_ptr_q]   <= bus.mem_rd;
      data_mem[wr_ptr_q] <= bus.mem_data;
    end
    if (alu_enq) begin
      rd_mem[wr_ptr_2nd]   <= bus.alu_rd;
      data_mem[wr_ptr_2nd] <= bus.alu_data;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [PTR_W-1:0] offset;
    assign offset          = PTR_W'(gi) - rd_ptr_q;
    assign entry_valid[gi] = {1'b0, offset} < count_q;
    assign hit1[gi]        = entry_valid[gi] && (rd_mem[gi] == bus.q_rs1);
    assign hit2[gi]        = entry_valid[gi] && (rd_mem[gi] == bus.q_rs2);
  end

  assign bus.pend1 = (bus.q_rs1 != '0) && ((|hit1) || (regwrite_q && (rd_q == bus.q_rs1)));
  assign bus.pend2 = (bus.q_rs2 != '0) && ((|hit2) || (regwrite_q && (rd_q == bus.q_rs2)));

  assign bus.mem_ready  = mem_ready;
  assign bus.alu_ready  = alu_ready;
  assign bus.RegWrite   = regwrite_q;
  assign bus.Rd         = rd_q;
  assign bus.Write_data = wdata_q;
  assign bus.count      = count_q;
endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Scoreboard bench for reg_writeback_arbiter: a queue-level model predicts every
// register-file write, occupancy, ready and pending flag.
module tb_reg_writeback_arbiter;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  wb_t           mdl_fifo[$];
  wb_t           exp_q[$];
  logic          mdl_out_v    = 1'b0;
  logic [AW-1:0] mdl_out_rd   = '0;
  logic          saw_alu_block = 1'b0;

  reg_writeback_arbiter_if #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) bus ();

  reg_writeback_arbiter #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic pend_model(input logic [AW-1:0] q);
    if (q == '0) return 1'b0;
    foreach (mdl_fifo[i]) if (mdl_fifo[i].rd == q) return 1'b1;
    return mdl_out_v && (mdl_out_rd == q);
  endfunction

  task automatic drive(input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                       input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                       input logic [AW-1:0] q1, input logic [AW-1:0] q2);
    bus.mem_valid = mv;  bus.mem_rd = mrd;  bus.mem_data = md;
    bus.alu_valid = av;  bus.alu_rd = ard;  bus.alu_data = ad;
    bus.q_rs1     = q1;  bus.q_rs2  = q2;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference model: acceptance from occupancy, one pop per edge, then pushes.
  initial begin
    int  free;
    logic macc, aacc;
    wb_t e;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mdl_fifo.delete();
        exp_q.delete();
        mdl_out_v  = 1'b0;
        mdl_out_rd = '0;
      end else begin
        free = DEPTH - mdl_fifo.size();
        macc = bus.mem_valid && (free >= 1);
        aacc = bus.alu_valid && (free >= 2);
        if (mdl_fifo.size() > 0) begin
          e          = mdl_fifo.pop_front();
          mdl_out_v  = 1'b1;
          mdl_out_rd = e.rd;
        end else begin
          mdl_out_v = 1'b0;
        end
        if (macc && bus.mem_rd != '0) begin
          e.rd = bus.mem_rd;  e.data = bus.mem_data;
          mdl_fifo.push_back(e);  exp_q.push_back(e);
        end
        if (aacc && bus.alu_rd != '0) begin
          e.rd = bus.alu_rd;  e.data = bus.alu_data;
          mdl_fifo.push_back(e);  exp_q.push_back(e);
        end
      end
    end
  end

  // Monitor: retires one expected write per RegWrite pulse and checks side-band state.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (bus.RegWrite === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wb_unexpected: got rd=%0d data=%h expected no write", bus.Rd, bus.Write_data);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] wb rd=%0d data=%h", bus.Rd, bus.Write_data);
          check("wb_rd", 64'(bus.Rd), 64'(e.rd));
          check("wb_data", 64'(bus.Write_data), 64'(e.data));
        end
      end
      check("regwrite", 64'(bus.RegWrite), 64'(mdl_out_v));
      check("count", 64'(bus.count), 64'(mdl_fifo.size()));
      check("mem_ready", 64'(bus.mem_ready), 64'(mdl_fifo.size() < DEPTH));
      check("alu_ready", 64'(bus.alu_ready), 64'(mdl_fifo.size() <= DEPTH - 2));
      check("pend1", 64'(bus.pend1), 64'(pend_model(bus.q_rs1)));
      check("pend2", 64'(bus.pend2), 64'(pend_model(bus.q_rs2)));
    end
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    check("reset_count", 64'(bus.count), 64'd0);
    check("reset_regwrite", 64'(bus.RegWrite), 64'd0);
    rst = 1'b0;

    // Single mem write: RegWrite high for exactly one cycle after acceptance.
    drive(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("t2_regwrite", 64'(bus.RegWrite), 64'd1);
    check("t2_rd", 64'(bus.Rd), 64'd5);
    check("t2_data", 64'(bus.Write_data), 64'hDEAD_BEEF);
    step();
    check("t2_regwrite_low", 64'(bus.RegWrite), 64'd0);

    // Simultaneous mem and alu: mem drains first.
    drive(1, 3, 32'h11, 1, 7, 32'h22, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("t3_first_rd", 64'(bus.Rd), 64'd3);
    step();
    check("t3_second_rd", 64'(bus.Rd), 64'd7);
    check("t3_second_data", 64'(bus.Write_data), 64'h22);
    repeat (2) step();

    // Write to x0 is consumed but never reaches the register file.
    check("t4_alu_ready", 64'(bus.alu_ready), 64'd1);
    drive(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_count", 64'(bus.count), 64'd0);
    step();
    check("t4_regwrite", 64'(bus.RegWrite), 64'd0);
    repeat (2) step();

    // Both producers every cycle: backpressure on alu, nothing lost or reordered.
    for (int i = 0; i < 20; i++) begin
      drive(1, 5'($urandom_range(1, 31)), $urandom, 1, 5'($urandom_range(1, 31)), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      step();
      if (bus.alu_ready === 1'b0) saw_alu_block = 1'b1;
    end
    check("t5_alu_throttled", 64'(saw_alu_block), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (6) step();

    // Pending lookup tracks rd=9 through the queue and the write pulse.
    drive(1, 9, 32'h99, 0, 0, 0, 9, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 9, 0);
    #1;
    check("t6_pend1_queued", 64'(bus.pend1), 64'd1);
    check("t6_pend2_zero", 64'(bus.pend2), 64'd0);
    step();
    check("t6_pend1_inflight", 64'(bus.pend1), 64'd1);
    check("t6_regwrite", 64'(bus.RegWrite), 64'd1);
    step();
    check("t6_pend1_clear", 64'(bus.pend1), 64'd0);
    repeat (2) step();

    // Asynchronous reset with three entries queued.
    drive(1, 1, 32'hA1, 1, 2, 32'hA2, 1, 0);
    step();
    drive(1, 3, 32'hA3, 1, 4, 32'hA4, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check("t1_count_before", 64'(bus.count), 64'd3);
    check("t1_pend1_before", 64'(bus.pend1), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("t1_regwrite_async", 64'(bus.RegWrite), 64'd0);
    check("t1_count_async", 64'(bus.count), 64'd0);
    check("t1_pend1_async", 64'(bus.pend1), 64'd0);
    step();
    rst = 1'b0;
    drive(1, 6, 32'h66, 0, 0, 0, 6, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 6, 0);
    step();
    check("t1_after_rd", 64'(bus.Rd), 64'd6);
    check("t1_after_data", 64'(bus.Write_data), 64'h66);
    repeat (2) step();

    // Randomized traffic, including x0 targets and overlapping queries.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (8) step();
    check("drain_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("drain_count", 64'(bus.count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
